pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with a return-address stack.
//
// Each rising edge performs at most one operation. The priority is
// load > call > ret > branch > increment. A lower-priority request that
// arrives together with a higher one is dropped.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   enabled      permits call, ret, branch and increment (load ignores it)
//   load         absolute jump to load_data
//   call         push outValue+1 and jump to load_data
//   ret          pop the top return address into the PC
//   branch       relative jump by sign-extended offset
//   clr_err      synchronous clear of the sticky stack_err flag
//   load_data    jump/call target
//   offset       two's-complement branch offset
//   outValue     current program counter (registered)
//   stack_depth  number of entries currently on the stack
//   stack_full   stack_depth == STACK_DEPTH (registered)
//   stack_empty  stack_depth == 0 (registered)
//   stack_err    sticky overflow/underflow flag
module pc_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  parameter int OFFSET_W    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enabled,
  input  logic                             load,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             branch,
  input  logic                             clr_err,
  input  logic [ADDR_W-1:0]                load_data,
  input  logic [OFFSET_W-1:0]              offset,
  output logic [ADDR_W-1:0]                outValue,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             stack_err
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               err_q, err_d;

  // Entry contents are not reset; depth_q alone decides which entries are valid.
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic               push_s;
  logic               err_set_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  off_ext_s;
  logic [DEPTH_W-1:0] depth_m1_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic               at_full_s;
  logic               at_empty_s;

  assign pc_inc_s   = pc_q + ADDR_W'(1'b1);
  // The size cast of a signed operand sign-extends the offset to ADDR_W bits.
  assign off_ext_s  = ADDR_W'($signed(offset));
  assign depth_m1_s = depth_q - DEPTH_W'(1'b1);
  // The push slot is the current depth; the top of the stack sits one below it.
  assign wr_idx_s   = depth_q[IDX_W-1:0];
  assign rd_idx_s   = depth_m1_s[IDX_W-1:0];
  assign at_full_s  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign at_empty_s = (depth_q == DEPTH_W'(1'b0));

  // Next-state logic: choose one operation by priority and update PC, depth and error.
  always_comb begin
    pc_d      = pc_q;
    depth_d   = depth_q;
    push_s    = 1'b0;
    err_set_s = 1'b0;

    if (load) begin
      pc_d = load_data;
    end else if (enabled) begin
      if (call) begin
        if (!at_full_s) begin
          push_s  = 1'b1;
          pc_d    = load_data;
          depth_d = depth_q + DEPTH_W'(1'b1);
        end else begin
          err_set_s = 1'b1;
        end
      end else if (ret) begin
        if (!at_empty_s) begin
          pc_d    = stack_q[rd_idx_s];
          depth_d = depth_m1_s;
        end else begin
          err_set_s = 1'b1;
        end
      end else if (branch) begin
        pc_d = pc_q + off_ext_s;
      end else begin
        pc_d = pc_inc_s;
      end
    end else begin
      pc_d = pc_q;
    end

    // An error raised in the same cycle as clr_err still sets the flag.
    if (clr_err) begin
      err_d = err_set_s;
    end else begin
      err_d = err_q | err_set_s;
    end

    full_d  = (depth_d == DEPTH_W'(STACK_DEPTH));
    empty_d = (depth_d == DEPTH_W'(1'b0));
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= {ADDR_W{1'b0}};
      depth_q <= {DEPTH_W{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage, written only on a successful push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[wr_idx_s] <= pc_inc_s;
    end
  end

  assign outValue    = pc_q;
  assign stack_depth = depth_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random operations,
// all compared against a queue-based reference model.
module tb_pc_sequencer;

  localparam int AW = 12;
  localparam int SD = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enabled, load, call, ret, branch, clr_err;
  logic [AW-1:0] load_data;
  logic [OW-1:0] offset;
  logic [AW-1:0] outValue;
  logic [2:0]    stack_depth;
  logic          stack_full, stack_empty, stack_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_pc;
  int m_stack[$];
  bit m_err;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .OFFSET_W(OW)) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .load(load), .call(call),
    .ret(ret), .branch(branch), .clr_err(clr_err), .load_data(load_data),
    .offset(offset), .outValue(outValue), .stack_depth(stack_depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(outValue),    32'(m_pc));
    check({tag, ".depth"}, 32'(stack_depth), 32'(m_stack.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == SD));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".err"},   32'(stack_err),   32'(m_err));
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  // One clock of behaviour, written directly from the operation rules.
  function automatic void model_step(bit l, bit c, bit r, bit b, bit e, bit clr,
                                     int ld, logic [OW-1:0] off);
    bit err_new = 1'b0;
    int mask = (1 << AW) - 1;
    if (l) begin
      m_pc = ld;
    end else if (e) begin
      if (c) begin
        if (m_stack.size() < SD) begin
          m_stack.push_back((m_pc + 1) & mask);
          m_pc = ld;
        end else begin
          err_new = 1'b1;
        end
      end else if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else err_new = 1'b1;
      end else if (b) begin
        m_pc = (m_pc + int'($signed(off))) & mask;
      end else begin
        m_pc = (m_pc + 1) & mask;
      end
    end
    m_err = clr ? err_new : (m_err | err_new);
  endfunction

  // Drive one operation from a falling edge, clock it, then check on the next falling edge.
  task automatic step(input string tag, input bit l, input bit c, input bit r, input bit b,
                      input bit e, input bit clr, input logic [AW-1:0] ld,
                      input logic [OW-1:0] off);
    load = l; call = c; ret = r; branch = b; enabled = e; clr_err = clr;
    load_data = ld; offset = off;
    @(posedge clk);
    model_step(l, c, r, b, e, clr, int'(ld), off);
    @(negedge clk);
    load = 1'b0; call = 1'b0; ret = 1'b0; branch = 1'b0; enabled = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enabled = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    branch = 1'b0; clr_err = 1'b0; load_data = '0; offset = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Increment from reset, then wrap across the top of the address space.
    for (int i = 1; i <= 5; i++) begin
      step("inc", 0, 0, 0, 0, 1, 0, 12'h000, 8'h00);
      check("inc.lit", 32'(outValue), 32'(i));
    end
    step("load_ffe", 1, 0, 0, 0, 0, 0, 12'hFFE, 8'h00);
    step("wrap1", 0, 0, 0, 0, 1, 0, 12'h000, 8'h00);
    step("wrap2", 0, 0, 0, 0, 1, 0, 12'h000, 8'h00);
    check("wrap.lit", 32'(outValue), 32'h000);
    step("wrap3", 0, 0, 0, 0, 1, 0, 12'h000, 8'h00);

    // Nested call / return.
    step("ld010", 1, 0, 0, 0, 1, 0, 12'h010, 8'h00);
    step("call100", 0, 1, 0, 0, 1, 0, 12'h100, 8'h00);
    step("call200", 0, 1, 0, 0, 1, 0, 12'h200, 8'h00);
    check("call200.depth.lit", 32'(stack_depth), 32'd2);
    step("ret1", 0, 0, 1, 0, 1, 0, 12'h000, 8'h00);
    check("ret1.lit", 32'(outValue), 32'h101);
    step("ret2", 0, 0, 1, 0, 1, 0, 12'h000, 8'h00);
    check("ret2.lit", 32'(outValue), 32'h011);

    // Overflow, then clear.
    for (int i = 0; i < 4; i++) step("fill", 0, 1, 0, 0, 1, 0, 12'(12'h400 + i), 8'h00);
    step("overflow", 0, 1, 0, 0, 1, 0, 12'h300, 8'h00);
    check("overflow.lit.pc", 32'(outValue), 32'h403);
    check("overflow.lit.err", 32'(stack_err), 32'd1);
    step("clr_err", 0, 0, 0, 0, 0, 1, 12'h000, 8'h00);

    // Underflow and signed branches.
    do_reset();
    step("ld050", 1, 0, 0, 0, 0, 0, 12'h050, 8'h00);
    step("underflow", 0, 0, 1, 0, 1, 0, 12'h000, 8'h00);
    step("br_neg", 0, 0, 0, 1, 1, 0, 12'h000, 8'hF0);
    check("br_neg.lit", 32'(outValue), 32'h040);
    step("br_pos", 0, 0, 0, 1, 1, 0, 12'h000, 8'h7F);
    check("br_pos.lit", 32'(outValue), 32'h0BF);
    // A new error in the clearing cycle keeps the flag set.
    step("clr_vs_err", 0, 0, 1, 0, 1, 1, 12'h000, 8'h00);
    check("clr_vs_err.lit", 32'(stack_err), 32'd1);
    step("clr_only", 0, 0, 0, 0, 0, 1, 12'h000, 8'h00);

    // Priority and enable gating.
    step("call123", 0, 1, 0, 0, 1, 0, 12'h123, 8'h00);
    step("prio", 1, 1, 0, 1, 1, 0, 12'h0AA, 8'h05);
    check("prio.lit", 32'(outValue), 32'h0AA);
    step("disabled", 0, 1, 0, 0, 0, 0, 12'h300, 8'h00);

    // Asynchronous reset between edges with three entries stacked.
    step("call_a", 0, 1, 0, 0, 1, 0, 12'h222, 8'h00);
    step("call_b", 0, 1, 0, 0, 1, 0, 12'h333, 8'h00);
    check("depth3.lit", 32'(stack_depth), 32'd3);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step("ret_after_reset", 0, 0, 1, 0, 1, 0, 12'h000, 8'h00);

    // Random operations against the model.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
           12'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
